// File: rtl/quadra_driver.sv
// Transmit-side driver for the quadra pipeline: credit-gated sample issue,
// result FIFO capture and sticky protocol error flags.
module quadra_driver #(
    parameter int X_W       = 16,
    parameter int Y_W       = 32,
    parameter int RES_DEPTH = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [X_W-1:0]                 in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [X_W-1:0]                 x,
    output logic                           x_dv,
    input  logic [Y_W-1:0]                 y,
    input  logic                           y_dv,
    output logic [Y_W-1:0]                 res_data,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [$clog2(RES_DEPTH+1)-1:0] inflight,
    output logic                           err_unexpected,
    output logic                           err_timeout
);

    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [Y_W-1:0]   mem [RES_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic [TMR_W-1:0] timer;
    logic [CNT_W:0]   used;
    logic             issue;
    logic             ret;
    logic             pop;

    // Every issued sample reserves a FIFO slot until its result is popped,
    // so the pipeline can never deliver into a full FIFO.
    assign used     = {1'b0, inflight} + {1'b0, fifo_count};
    assign in_ready = !rst && en && (used < (CNT_W+1)'(RES_DEPTH)) && !err_timeout;
    assign issue    = in_valid && in_ready;
    assign ret      = y_dv && (inflight != '0);
    assign pop      = res_valid && res_ready;

    assign res_valid = (fifo_count != '0);
    assign res_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            x_dv <= 1'b0;
        end else begin
            x_dv <= issue;
            if (issue) begin
                x <= in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            case ({issue, ret})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (ret) begin
                mem[wr_ptr] <= y;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({ret, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer          <= '0;
            err_timeout    <= 1'b0;
            err_unexpected <= 1'b0;
        end else begin
            if (y_dv && (inflight == '0)) begin
                err_unexpected <= 1'b1;
            end
            if (y_dv || (inflight == '0)) begin
                timer <= '0;
            end else if (timer != TMR_W'(TIMEOUT)) begin
                timer <= timer + TMR_W'(1);
            end
            // The flag rises on the edge where the counter reaches TIMEOUT.
            if (!y_dv && (inflight != '0) && (timer == TMR_W'(TIMEOUT - 1))) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_quadra_driver.sv
// Directed bench for quadra_driver with a 3-stage squaring pipeline model
// feeding y/y_dv back from x/x_dv.
module tb_quadra_driver;

    localparam int X_W       = 16;
    localparam int Y_W       = 32;
    localparam int RES_DEPTH = 8;
    localparam int TIMEOUT   = 15;
    localparam int CNT_W     = $clog2(RES_DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [X_W-1:0]   in_data;
    logic             in_valid;
    logic             in_ready;
    logic [X_W-1:0]   x;
    logic             x_dv;
    logic [Y_W-1:0]   y;
    logic             y_dv;
    logic [Y_W-1:0]   res_data;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] inflight;
    logic             err_unexpected;
    logic             err_timeout;

    logic             model_en;
    logic             inj_dv;
    logic [Y_W-1:0]   inj_y;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    quadra_driver #(
        .X_W(X_W), .Y_W(Y_W), .RES_DEPTH(RES_DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .x_dv(x_dv), .y(y), .y_dv(y_dv),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .inflight(inflight), .err_unexpected(err_unexpected), .err_timeout(err_timeout)
    );

    // Pipeline model: y = x*x, three register stages, never reset.
    logic           m1_dv = 1'b0, m2_dv = 1'b0, m3_dv = 1'b0;
    logic [Y_W-1:0] m1_y = '0, m2_y = '0, m3_y = '0;

    always @(posedge clk) begin
        m1_dv <= x_dv;
        m1_y  <= {16'h0, x} * {16'h0, x};
        m2_dv <= m1_dv;
        m2_y  <= m1_y;
        m3_dv <= m2_dv;
        m3_y  <= m2_y;
    end

    assign y_dv = inj_dv | (model_en & m3_dv);
    assign y    = inj_dv ? inj_y : m3_y;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        model_en = 1'b1; inj_dv = 1'b0; inj_y = '0;
        tick();
        tick();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
        vectors++; if (x_dv !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_x_dv: got %b want 0", x_dv); end
        vectors++; if (x !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_x: got %h want 0", x); end
        vectors++; if (inflight !== 4'd0) begin miscompares++; $display("[TB] FAIL reset_inflight: got %0d want 0", inflight); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_res_valid: got %b want 0", res_valid); end
        vectors++; if (res_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_res_data: got %h want 0", res_data); end
        vectors++; if (err_unexpected !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err_unexpected: got %b want 0", err_unexpected); end
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err_timeout: got %b want 0", err_timeout); end
        rst = 1'b0;
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        in_data = 16'h0005; in_valid = 1'b1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL single_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (x !== 16'h0005) begin miscompares++; $display("[TB] FAIL single_x: got %h want 0005", x); end
        vectors++; if (x_dv !== 1'b1) begin miscompares++; $display("[TB] FAIL single_x_dv: got %b want 1", x_dv); end
        vectors++; if (inflight !== 4'd1) begin miscompares++; $display("[TB] FAIL single_inflight: got %0d want 1", inflight); end
        tick();
        vectors++; if (x_dv !== 1'b0) begin miscompares++; $display("[TB] FAIL single_x_dv_drop: got %b want 0", x_dv); end
        tick();
        tick();
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_res_valid_early: got %b want 0", res_valid); end
        tick();
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL single_res_valid: got %b want 1", res_valid); end
        vectors++; if (res_data !== 32'h19) begin miscompares++; $display("[TB] FAIL single_res_data: got %h want 19", res_data); end
        vectors++; if (inflight !== 4'd0) begin miscompares++; $display("[TB] FAIL single_inflight_end: got %0d want 0", inflight); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL single_res_popped: got %b want 0", res_valid); end
    endtask

    task automatic test_credit();
        int acc;
        int pops;
        logic exp_rdy;
        logic [31:0] exp_y;
        acc = 0; pops = 0;
        res_ready = 1'b0;
        for (int c = 0; c < 30; c++) begin
            in_valid = (acc < 20);
            in_data  = 16'(acc);
            exp_rdy  = ((acc - pops) < RES_DEPTH);
            vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("[TB] FAIL credit_fill_in_ready: cycle %0d got %b want %b", c, in_ready, exp_rdy); end
            if (in_valid && in_ready === 1'b1) acc++;
            tick();
        end
        vectors++; if (acc !== 8) begin miscompares++; $display("[TB] FAIL credit_accepted: got %0d want 8", acc); end
        vectors++; if (inflight !== 4'd0) begin miscompares++; $display("[TB] FAIL credit_inflight_full: got %0d want 0", inflight); end
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL credit_res_valid_full: got %b want 1", res_valid); end
        res_ready = 1'b1;
        for (int c = 0; c < 200 && pops < 20; c++) begin
            in_valid = (acc < 20);
            in_data  = 16'(acc);
            exp_rdy  = ((acc - pops) < RES_DEPTH);
            vectors++; if (in_ready !== exp_rdy) begin miscompares++; $display("[TB] FAIL credit_drain_in_ready: cycle %0d got %b want %b", c, in_ready, exp_rdy); end
            if (in_valid && in_ready === 1'b1) acc++;
            if (res_valid === 1'b1) begin
                exp_y = 32'(pops * pops);
                vectors++; if (res_data !== exp_y) begin miscompares++; $display("[TB] FAIL credit_order: result %0d got %h want %h", pops, res_data, exp_y); end
                pops++;
            end
            tick();
        end
        in_valid = 1'b0;
        res_ready = 1'b0;
        vectors++; if (pops !== 20) begin miscompares++; $display("[TB] FAIL credit_results: got %0d want 20", pops); end
        vectors++; if (acc !== 20) begin miscompares++; $display("[TB] FAIL credit_total_accepted: got %0d want 20", acc); end
    endtask

    task automatic test_back_to_back();
        int acc;
        int pops;
        logic [31:0] exp_y;
        acc = 0; pops = 0;
        res_ready = 1'b1;
        for (int c = 0; c < 100 && pops < 30; c++) begin
            in_valid = (acc < 30);
            in_data  = 16'(100 + acc);
            if (c >= 4 && c <= 30) begin
                vectors++; if (inflight !== 4'd4) begin miscompares++; $display("[TB] FAIL b2b_inflight: cycle %0d got %0d want 4", c, inflight); end
            end
            if (in_valid && in_ready === 1'b1) acc++;
            if (res_valid === 1'b1) begin
                exp_y = 32'((100 + pops) * (100 + pops));
                vectors++; if (res_data !== exp_y) begin miscompares++; $display("[TB] FAIL b2b_order: result %0d got %h want %h", pops, res_data, exp_y); end
                pops++;
            end
            tick();
        end
        in_valid = 1'b0;
        res_ready = 1'b0;
        vectors++; if (pops !== 30) begin miscompares++; $display("[TB] FAIL b2b_results: got %0d want 30", pops); end
        vectors++; if (inflight !== 4'd0) begin miscompares++; $display("[TB] FAIL b2b_inflight_end: got %0d want 0", inflight); end
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_err_timeout: got %b want 0", err_timeout); end
    endtask

    task automatic test_unexpected();
        apply_reset();
        vectors++; if (err_unexpected !== 1'b0) begin miscompares++; $display("[TB] FAIL unexp_pre: got %b want 0", err_unexpected); end
        inj_dv = 1'b1; inj_y = 32'hABCD;
        tick();
        inj_dv = 1'b0;
        vectors++; if (err_unexpected !== 1'b1) begin miscompares++; $display("[TB] FAIL unexp_flag: got %b want 1", err_unexpected); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL unexp_res_valid: got %b want 0", res_valid); end
        vectors++; if (inflight !== 4'd0) begin miscompares++; $display("[TB] FAIL unexp_inflight: got %0d want 0", inflight); end
        tick();
        vectors++; if (err_unexpected !== 1'b1) begin miscompares++; $display("[TB] FAIL unexp_sticky: got %b want 1", err_unexpected); end
    endtask

    task automatic test_timeout();
        apply_reset();
        model_en = 1'b0;
        in_valid = 1'b1; in_data = 16'h0042;
        tick();
        in_valid = 1'b0;
        vectors++; if (x_dv !== 1'b1 || x !== 16'h0042) begin miscompares++; $display("[TB] FAIL tmo_issue: got x_dv=%b x=%h want 1/0042", x_dv, x); end
        for (int k = 1; k < TIMEOUT; k++) begin
            tick();
            vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_early: cycle %0d got %b want 0", k, err_timeout); end
        end
        tick();
        vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_flag: got %b want 1", err_timeout); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_in_ready: got %b want 0", in_ready); end
        vectors++; if (inflight !== 4'd1) begin miscompares++; $display("[TB] FAIL tmo_inflight: got %0d want 1", inflight); end
        tick();
        vectors++; if (err_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_sticky: got %b want 1", err_timeout); end
        rst = 1'b1;
        #1;
        vectors++; if (err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_rst_flag: got %b want 0", err_timeout); end
        vectors++; if (inflight !== 4'd0) begin miscompares++; $display("[TB] FAIL tmo_rst_inflight: got %0d want 0", inflight); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_rst_in_ready: got %b want 0", in_ready); end
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_release_in_ready: got %b want 1", in_ready); end
        model_en = 1'b1;
    endtask

    task automatic test_reset_midflight();
        logic [31:0] exp_y;
        apply_reset();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(200 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        exp_y = 32'(200 * 200);
        vectors++; if (inflight !== 4'd3) begin miscompares++; $display("[TB] FAIL mid_inflight: got %0d want 3", inflight); end
        vectors++; if (res_valid !== 1'b1 || res_data !== exp_y) begin miscompares++; $display("[TB] FAIL mid_head: got %b/%h want 1/%h", res_valid, res_data, exp_y); end
        rst = 1'b1;
        #1;
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_res_valid: got %b want 0", res_valid); end
        vectors++; if (inflight !== 4'd0) begin miscompares++; $display("[TB] FAIL mid_rst_inflight: got %0d want 0", inflight); end
        vectors++; if (res_data !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_rst_res_data: got %h want 0", res_data); end
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (err_unexpected !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_late_unexpected: got %b want 1", err_unexpected); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_late_res_valid: got %b want 0", res_valid); end
        vectors++; if (inflight !== 4'd0) begin miscompares++; $display("[TB] FAIL mid_late_inflight: got %0d want 0", inflight); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit();
        test_back_to_back();
        test_unexpected();
        test_timeout();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
